// File: rtl/uart_pkg.sv
// Shared UART arbiter types and constants.
package uart_pkg;

  localparam int UART_BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_ACK,
    WAIT_DONE
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic [ID_W-1:0]  winner_o,
  output logic             any_o
);

  logic [2*N_REQ-1:0] dbl;
  logic [ID_W:0]      idx;
  logic               found;

  // Lower copy is masked below the pointer; the upper copy supplies the wrap-around.
  always_comb begin
    dbl = {req_i, req_i};
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (i < 32'(ptr_i)) dbl[i] = 1'b0;
    end
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < 2*N_REQ; i++) begin
      if (!found && dbl[i]) begin
        found = 1'b1;
        idx   = (ID_W+1)'(i);
      end
    end
    any_o    = |req_i;
    winner_o = (idx >= (ID_W+1)'(N_REQ)) ? ID_W'(idx - (ID_W+1)'(N_REQ)) : ID_W'(idx);
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter sharing one UART transmitter among N_REQ byte streams.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 16,
  parameter int ID_W      = $clog2(N_REQ)
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [UART_BYTE_W*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]             req_last,
  output logic [N_REQ-1:0]             req_ready,
  output logic                         tx_start,
  output logic [UART_BYTE_W-1:0]       tx_data,
  input  logic                         tx_busy,
  output logic                         grant_valid,
  output logic [ID_W-1:0]              grant_id
);

  localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

  arb_state_t             state_q;
  logic [N_REQ-1:0]       ready_q;
  logic                   start_q;
  logic [UART_BYTE_W-1:0] data_q;
  logic                   gvalid_q;
  logic [ID_W-1:0]        gid_q;
  logic [ID_W-1:0]        ptr_q;
  logic                   last_q;
  logic [7:0]             burst_q;

  logic [ID_W-1:0]        pick_win;
  logic                   pick_any;
  logic [ID_W-1:0]        ptr_d;
  logic [7:0]             burst_d;
  logic [UART_BYTE_W-1:0] hold_data;

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req_i    (req_valid),
    .ptr_i    (ptr_q),
    .winner_o (pick_win),
    .any_o    (pick_any)
  );

  assign ptr_d     = (gid_q == ID_W'(N_REQ-1)) ? '0 : gid_q + ID_W'(1);
  assign burst_d   = (burst_q == '1) ? burst_q : burst_q + 8'd1;
  assign hold_data = req_data[int'(gid_q)*UART_BYTE_W +: UART_BYTE_W];

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q  <= IDLE;
      ready_q  <= '0;
      start_q  <= 1'b0;
      data_q   <= '0;
      gvalid_q <= 1'b0;
      gid_q    <= '0;
      ptr_q    <= '0;
      last_q   <= 1'b0;
      burst_q  <= '0;
    end else begin
      start_q <= 1'b0;
      ready_q <= '0;
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            gid_q    <= pick_win;
            gvalid_q <= 1'b1;
            burst_q  <= '0;
            state_q  <= SEND;
          end
        end
        SEND: begin
          // A holder that drops valid gives up the grant even while the transmitter is busy.
          if (!req_valid[gid_q]) begin
            gvalid_q <= 1'b0;
            ptr_q    <= ptr_d;
            state_q  <= IDLE;
          end else if (!tx_busy) begin
            start_q        <= 1'b1;
            ready_q[gid_q] <= 1'b1;
            data_q         <= hold_data;
            last_q         <= req_last[gid_q];
            burst_q        <= burst_d;
            state_q        <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (tx_busy) state_q <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            if (last_q || burst_q == BURST_MAX) begin
              gvalid_q <= 1'b0;
              ptr_q    <= ptr_d;
              state_q  <= IDLE;
            end else begin
              state_q <= SEND;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready   = ready_q;
  assign tx_start    = start_q;
  assign tx_data     = data_q;
  assign grant_valid = gvalid_q;
  assign grant_id    = gid_q;

endmodule
